// File: rtl/l2_req_sched.sv
// Round-robin scheduler sharing one L2 request port among per-stream requesters,
// with a tag table that routes out-of-order L2 responses back to their streams.
module l2_req_sched #(
  parameter int nstrms    = 64,
  parameter int sid_width = $clog2(nstrms),
  parameter int ntags     = 8,
  parameter int tag_width = $clog2(ntags)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [nstrms-1:0]    i_req_v,
  output logic [nstrms-1:0]    i_req_r,
  output logic                 o_mreq_v,
  input  logic                 o_mreq_r,
  output logic [sid_width-1:0] o_mreq_sid,
  output logic [tag_width-1:0] o_mreq_tag,
  input  logic                 i_mrsp_v,
  output logic                 i_mrsp_r,
  input  logic [tag_width-1:0] i_mrsp_tag,
  output logic [nstrms-1:0]    o_rsp_v,
  input  logic [nstrms-1:0]    o_rsp_r,
  output logic                 o_err
);

  localparam logic [sid_width:0]   nstrms_w = (sid_width+1)'(nstrms);
  localparam logic [sid_width-1:0] last_sid = sid_width'(nstrms - 1);

  logic [sid_width-1:0] rr_q, rr_d;
  logic [ntags-1:0]     busy_q, busy_d;
  logic [sid_width-1:0] tag_sid_q [ntags];
  logic [sid_width-1:0] tag_sid_d [ntags];
  logic                 mreq_v_q, mreq_v_d;
  logic [sid_width-1:0] mreq_sid_q, mreq_sid_d;
  logic [tag_width-1:0] mreq_tag_q, mreq_tag_d;
  logic                 rsp_v_q, rsp_v_d;
  logic [sid_width-1:0] rsp_sid_q, rsp_sid_d;
  logic [tag_width-1:0] rsp_tag_q, rsp_tag_d;
  logic                 err_q, err_d;

  logic                 win_found_s;
  logic [sid_width-1:0] win_sid_s;
  logic [sid_width:0]   scan_sum_s;
  logic [sid_width-1:0] scan_idx_s;
  logic                 tag_found_s;
  logic [tag_width-1:0] free_tag_s;
  logic                 mreq_fire_s;
  logic                 deliver_s;
  logic                 grant_s;
  logic                 mrsp_rdy_s;
  logic                 rsp_acc_s;

  // Round-robin scan: first requesting stream at or after rr, wrapping modulo nstrms
  always_comb begin
    win_found_s = 1'b0;
    win_sid_s   = '0;
    scan_sum_s  = '0;
    scan_idx_s  = '0;
    for (int i = 0; i < nstrms; i++) begin
      scan_sum_s = {1'b0, rr_q} + (sid_width+1)'(i);
      if (scan_sum_s >= nstrms_w) begin
        scan_sum_s = scan_sum_s - nstrms_w;
      end else begin
        scan_sum_s = scan_sum_s;
      end
      scan_idx_s = scan_sum_s[sid_width-1:0];
      if (!win_found_s && i_req_v[scan_idx_s]) begin
        win_found_s = 1'b1;
        win_sid_s   = scan_idx_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Lowest free tag, judged on registered busy bits so a tag freed this cycle is not reused
  always_comb begin
    tag_found_s = 1'b0;
    free_tag_s  = '0;
    for (int t = 0; t < ntags; t++) begin
      if (!tag_found_s && !busy_q[t]) begin
        tag_found_s = 1'b1;
        free_tag_s  = tag_width'(t);
      end else begin
        tag_found_s = tag_found_s;
      end
    end
  end

  // Handshake qualifiers; grants are blocked while reset is asserted
  always_comb begin
    mreq_fire_s = mreq_v_q & o_mreq_r;
    deliver_s   = rsp_v_q & o_rsp_r[rsp_sid_q];
    grant_s     = reset & win_found_s & tag_found_s & (~mreq_v_q | mreq_fire_s);
    mrsp_rdy_s  = ~rsp_v_q | deliver_s;
    rsp_acc_s   = i_mrsp_v & mrsp_rdy_s;
  end

  // Next-state for pointer, tag table and the two output registers
  always_comb begin
    rr_d       = rr_q;
    busy_d     = busy_q;
    tag_sid_d  = tag_sid_q;
    mreq_v_d   = mreq_v_q;
    mreq_sid_d = mreq_sid_q;
    mreq_tag_d = mreq_tag_q;
    rsp_v_d    = rsp_v_q;
    rsp_sid_d  = rsp_sid_q;
    rsp_tag_d  = rsp_tag_q;
    err_d      = 1'b0;

    if (deliver_s) begin
      busy_d[rsp_tag_q] = 1'b0;
      rsp_v_d           = 1'b0;
    end else begin
      rsp_v_d = rsp_v_q;
    end

    if (rsp_acc_s) begin
      if (busy_q[i_mrsp_tag]) begin
        rsp_v_d   = 1'b1;
        rsp_sid_d = tag_sid_q[i_mrsp_tag];
        rsp_tag_d = i_mrsp_tag;
      end else begin
        err_d = 1'b1;
      end
    end else begin
      err_d = 1'b0;
    end

    if (grant_s) begin
      rr_d                  = (win_sid_s == last_sid) ? '0 : win_sid_s + 1'b1;
      busy_d[free_tag_s]    = 1'b1;
      tag_sid_d[free_tag_s] = win_sid_s;
      mreq_v_d              = 1'b1;
      mreq_sid_d            = win_sid_s;
      mreq_tag_d            = free_tag_s;
    end else if (mreq_fire_s) begin
      mreq_v_d = 1'b0;
    end else begin
      mreq_v_d = mreq_v_q;
    end
  end

  // State registers; reset discards every outstanding tag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_q       <= '0;
      busy_q     <= '0;
      for (int t = 0; t < ntags; t++) begin
        tag_sid_q[t] <= '0;
      end
      mreq_v_q   <= 1'b0;
      mreq_sid_q <= '0;
      mreq_tag_q <= '0;
      rsp_v_q    <= 1'b0;
      rsp_sid_q  <= '0;
      rsp_tag_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      busy_q     <= busy_d;
      tag_sid_q  <= tag_sid_d;
      mreq_v_q   <= mreq_v_d;
      mreq_sid_q <= mreq_sid_d;
      mreq_tag_q <= mreq_tag_d;
      rsp_v_q    <= rsp_v_d;
      rsp_sid_q  <= rsp_sid_d;
      rsp_tag_q  <= rsp_tag_d;
      err_q      <= err_d;
    end
  end

  // One-hot decode of the grant and of the pending response
  always_comb begin
    i_req_r = '0;
    o_rsp_v = '0;
    if (grant_s) begin
      i_req_r[win_sid_s] = 1'b1;
    end else begin
      i_req_r = '0;
    end
    if (rsp_v_q) begin
      o_rsp_v[rsp_sid_q] = 1'b1;
    end else begin
      o_rsp_v = '0;
    end
  end

  assign o_mreq_v   = mreq_v_q;
  assign o_mreq_sid = mreq_sid_q;
  assign o_mreq_tag = mreq_tag_q;
  assign i_mrsp_r   = mrsp_rdy_s;
  assign o_err      = err_q;

endmodule
